// File: rtl/pic27_ack_sequencer.sv
// Request-side companion to the 27-channel priority interrupt controller:
// edge-latched pending vectors, CPU irq/ack handshake and one-hot source acknowledge.
module pic27_ack_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] req_a,
  input  logic [8:0] req_b,
  input  logic [8:0] req_c,
  output logic [8:0] pend_a,
  output logic [8:0] pend_b,
  output logic [8:0] pend_c,
  input  logic       grp_a,
  input  logic       grp_b,
  input  logic       grp_c,
  input  logic [3:0] chan_id,
  output logic       irq,
  input  logic       cpu_ack,
  output logic [5:0] vec,
  output logic [8:0] ack_a,
  output logic [8:0] ack_b,
  output logic [8:0] ack_c,
  output logic       err
);

  localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, ACK, RELEASE} state_t;

  state_t         state, state_n;
  logic [26:0]    req, req_q, pend, ack, ack_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           irq_n, err_n, grant;
  logic [5:0]     vec_n;
  logic [1:0]     grp_code;
  logic [8:0]     onehot;

  assign req = {req_c, req_b, req_a};
  assign {pend_c, pend_b, pend_a} = pend;
  assign {ack_c, ack_b, ack_a} = ack;

  always_comb begin
    grant    = grp_a | grp_b | grp_c;
    grp_code = grp_a ? 2'd1 : (grp_b ? 2'd2 : 2'd3);
    onehot   = 9'd1 << vec[3:0];
    state_n  = state;
    cnt_n    = cnt;
    irq_n    = irq;
    vec_n    = vec;
    err_n    = err;
    ack_n    = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          if (chan_id <= 4'd8) begin
            vec_n   = {grp_code, chan_id};
            irq_n   = 1'b1;
            cnt_n   = '0;
            state_n = WAIT_ACK;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (cpu_ack) begin
          irq_n   = 1'b0;
          state_n = ACK;
        end else if (ACK_TIMEOUT != 0 && cnt == CNT_LAST) begin
          // pending bit is left set so the controller re-grants it
          err_n   = 1'b1;
          irq_n   = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ACK: begin
        state_n = RELEASE;
        case (vec[5:4])
          2'd1:    ack_n[8:0]   = onehot;
          2'd2:    ack_n[17:9]  = onehot;
          default: ack_n[26:18] = onehot;
        endcase
      end
      RELEASE: begin
        if (!cpu_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
      pend  <= '0;
      ack   <= '0;
      cnt   <= '0;
      irq   <= 1'b0;
      vec   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= req;
      // clear driven by the visible ack pulse; a fresh edge in that cycle wins
      pend  <= (pend & ~ack) | (req & ~req_q);
      ack   <= ack_n;
      cnt   <= cnt_n;
      irq   <= irq_n;
      vec   <= vec_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_pic27_ack_sequencer.sv
// Self-checking bench for pic27_ack_sequencer: directed scenarios plus random
// request/ack traffic against a cycle-stamped handshake model.
module tb_pic27_ack_sequencer;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] req_a, req_b, req_c;
  logic [8:0] pend_a, pend_b, pend_c;
  logic       grp_a, grp_b, grp_c;
  logic [3:0] chan_id;
  logic       irq, cpu_ack, err;
  logic [5:0] vec;
  logic [8:0] ack_a, ack_b, ack_c;

  int vectors = 0;
  int miscompares = 0;

  pic27_ack_sequencer #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .pend_a(pend_a), .pend_b(pend_b), .pend_c(pend_c),
    .grp_a(grp_a), .grp_b(grp_b), .grp_c(grp_c), .chan_id(chan_id),
    .irq(irq), .cpu_ack(cpu_ack), .vec(vec),
    .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: m_wait counts cycles since capture (-1 = no request out),
  // m_due marks "ack pulse goes out next edge", m_rel marks "waiting for cpu_ack low".
  logic [26:0] m_reqq, m_pend, m_ack, n_ack;
  logic        m_irq, m_err, n_irq, n_err;
  logic [5:0]  m_vec, n_vec;
  int          m_wait, n_wait, idx;
  bit          m_due, n_due, m_rel, n_rel;

  // controller stimulus, optionally overridden by a scenario
  bit          ovr = 1'b0;
  logic        ovr_ga, ovr_gb, ovr_gc;
  logic [3:0]  ovr_ch;

  function automatic logic [3:0] lowest(input logic [8:0] v);
    logic [3:0] r = 4'd0;
    for (int i = 8; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always_comb begin
    grp_a = 1'b0; grp_b = 1'b0; grp_c = 1'b0; chan_id = 4'd0;
    if (ovr) begin
      grp_a = ovr_ga; grp_b = ovr_gb; grp_c = ovr_gc; chan_id = ovr_ch;
    end else if (|m_pend[8:0]) begin
      grp_a = 1'b1; chan_id = lowest(m_pend[8:0]);
    end else if (|m_pend[17:9]) begin
      grp_b = 1'b1; chan_id = lowest(m_pend[17:9]);
    end else if (|m_pend[26:18]) begin
      grp_c = 1'b1; chan_id = lowest(m_pend[26:18]);
    end
  end

  always_comb begin
    n_ack = '0; n_irq = m_irq; n_err = m_err; n_vec = m_vec;
    n_wait = m_wait; n_due = 1'b0; n_rel = m_rel; idx = 0;
    if (m_due) begin
      idx   = (int'(m_vec[5:4]) - 1) * 9 + int'(m_vec[3:0]);
      n_ack = 27'd1 << idx;
      n_rel = 1'b1;
    end else if (m_rel) begin
      if (!cpu_ack) n_rel = 1'b0;
    end else if (m_wait >= 0) begin
      if (cpu_ack) begin
        n_due = 1'b1; n_wait = -1; n_irq = 1'b0;
      end else if (m_wait + 1 == int'(TO)) begin
        n_err = 1'b1; n_irq = 1'b0; n_wait = -1;
      end else begin
        n_wait = m_wait + 1;
      end
    end else if (grp_a | grp_b | grp_c) begin
      if (chan_id <= 4'd8) begin
        n_vec  = {grp_a ? 2'd1 : (grp_b ? 2'd2 : 2'd3), chan_id};
        n_irq  = 1'b1;
        n_wait = 0;
      end else begin
        n_err = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_reqq <= '0; m_pend <= '0; m_ack <= '0; m_irq <= 1'b0; m_err <= 1'b0;
      m_vec <= '0; m_wait <= -1; m_due <= 1'b0; m_rel <= 1'b0;
    end else begin
      m_reqq <= {req_c, req_b, req_a};
      m_pend <= (m_pend & ~m_ack) | ({req_c, req_b, req_a} & ~m_reqq);
      m_ack  <= n_ack;
      m_irq  <= n_irq;
      m_err  <= n_err;
      m_vec  <= n_vec;
      m_wait <= n_wait;
      m_due  <= n_due;
      m_rel  <= n_rel;
    end
  end

  task automatic test_reset;
    rst = 1'b1; ovr = 1'b0; cpu_ack = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({pend_c, pend_b, pend_a, ack_c, ack_b, ack_a} !== 54'd0) begin
      miscompares++;
      $display("FAIL reset_pend_ack got %h want 0", {pend_c, pend_b, pend_a, ack_c, ack_b, ack_a});
    end
    vectors++;
    if ({irq, err, vec} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_irq_err_vec got %h want 00", {irq, err, vec});
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    req_b[4] = 1'b1;
    @(negedge clk);
    vectors++;
    if (pend_b !== 9'h010 || irq !== 1'b0) begin
      miscompares++; $display("FAIL single_pend got pend_b=%h irq=%b want 010/0", pend_b, irq);
    end
    req_b[4] = 1'b0;
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1 || vec !== 6'h24) begin
      miscompares++; $display("FAIL single_irq got irq=%b vec=%h want 1/24", irq, vec);
    end
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
    vectors++;
    if (irq !== 1'b0 || ack_b !== 9'h000) begin
      miscompares++; $display("FAIL single_ackcyc got irq=%b ack_b=%h want 0/000", irq, ack_b);
    end
    @(negedge clk);
    vectors++;
    if (ack_b !== 9'h010 || pend_b !== 9'h010) begin
      miscompares++; $display("FAIL single_ackpulse got ack_b=%h pend_b=%h want 010/010", ack_b, pend_b);
    end
    @(negedge clk);
    vectors++;
    if (ack_b !== 9'h000 || pend_b !== 9'h000) begin
      miscompares++; $display("FAIL single_clear got ack_b=%h pend_b=%h want 000/000", ack_b, pend_b);
    end
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    ovr = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      vectors++;
      if ({pend_c, pend_b, pend_a, ack_c, ack_b, ack_a, irq, vec, err} !==
          {m_pend, m_ack, m_irq, m_vec, m_err}) begin
        miscompares++;
        $display("FAIL %s_drain got %h want %h", tag,
                 {pend_c, pend_b, pend_a, ack_c, ack_b, ack_a, irq, vec, err},
                 {m_pend, m_ack, m_irq, m_vec, m_err});
      end
      cpu_ack = irq;
      done = (m_pend == '0) && (m_wait < 0) && !m_due && !m_rel;
    end
    cpu_ack = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++; $display("FAIL %s_drain_timeout got busy want idle", tag);
    end
  endtask

  task automatic test_group_priority;
    req_a[2] = 1'b1; req_c[2] = 1'b1;
    @(negedge clk);
    req_a[2] = 1'b0; req_c[2] = 1'b0;
    ovr = 1'b1; ovr_ga = 1'b1; ovr_gb = 1'b0; ovr_gc = 1'b1; ovr_ch = 4'd2;
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1 || vec !== 6'h12) begin
      miscompares++; $display("FAIL prio_vec got irq=%b vec=%h want 1/12", irq, vec);
    end
    ovr = 1'b0; cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (ack_a !== 9'h004 || ack_c !== 9'h000) begin
      miscompares++; $display("FAIL prio_ack got ack_a=%h ack_c=%h want 004/000", ack_a, ack_c);
    end
    @(negedge clk);
    vectors++;
    if (pend_a !== 9'h000 || pend_c !== 9'h004) begin
      miscompares++; $display("FAIL prio_pend got pend_a=%h pend_c=%h want 000/004", pend_a, pend_c);
    end
    drain("prio");
  endtask

  task automatic test_invalid_code;
    logic [5:0] prev_vec = m_vec;
    ovr = 1'b1; ovr_ga = 1'b1; ovr_gb = 1'b0; ovr_gc = 1'b0; ovr_ch = 4'd11;
    req_a[0] = 1'b1;
    @(negedge clk);
    req_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (err !== 1'b1 || irq !== 1'b0) begin
      miscompares++; $display("FAIL invalid_err got err=%b irq=%b want 1/0", err, irq);
    end
    vectors++;
    if ({pend_c, pend_b, pend_a} !== 27'h1 || vec !== prev_vec || {ack_c, ack_b, ack_a} !== 27'h0) begin
      miscompares++;
      $display("FAIL invalid_state got pend=%h vec=%h ack=%h want 0000001/%h/0",
               {pend_c, pend_b, pend_a}, vec, {ack_c, ack_b, ack_a}, prev_vec);
    end
    drain("invalid");
    vectors++;
    if (err !== 1'b1) begin
      miscompares++; $display("FAIL invalid_sticky got err=%b want 1", err);
    end
  endtask

  task automatic test_timeout;
    int high = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_a[5] = 1'b1;
    @(negedge clk);
    req_a[5] = 1'b0;
    @(negedge clk);
    while (irq === 1'b1 && high < 20) begin
      high++;
      @(negedge clk);
    end
    vectors++;
    if (high != int'(TO)) begin
      miscompares++; $display("FAIL timeout_len got %0d want %0d", high, TO);
    end
    vectors++;
    if (err !== 1'b1 || pend_a !== 9'h020 || irq !== 1'b0) begin
      miscompares++; $display("FAIL timeout_state got err=%b pend_a=%h irq=%b want 1/020/0", err, pend_a, irq);
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1 || vec !== 6'h15) begin
      miscompares++; $display("FAIL timeout_retry got irq=%b vec=%h want 1/15", irq, vec);
    end
    drain("timeout");
  endtask

  task automatic test_collision;
    req_c[8] = 1'b1;
    @(negedge clk);
    req_c[8] = 1'b0;
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1 || vec !== 6'h38) begin
      miscompares++; $display("FAIL coll_irq got irq=%b vec=%h want 1/38", irq, vec);
    end
    cpu_ack = 1'b1;
    @(negedge clk);
    cpu_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (ack_c !== 9'h100) begin
      miscompares++; $display("FAIL coll_ack got ack_c=%h want 100", ack_c);
    end
    req_c[8] = 1'b1;
    @(negedge clk);
    req_c[8] = 1'b0;
    vectors++;
    if (ack_c !== 9'h000 || pend_c !== 9'h100) begin
      miscompares++; $display("FAIL coll_pend got ack_c=%h pend_c=%h want 000/100", ack_c, pend_c);
    end
    drain("coll");
  endtask

  task automatic test_back_to_back;
    int rise1 = -1, rise2 = -1;
    logic [5:0] v1 = '0, v2 = '0;
    logic prev = 1'b0;
    req_a[1] = 1'b1; req_b[7] = 1'b1;
    @(negedge clk);
    req_a[1] = 1'b0; req_b[7] = 1'b0;
    for (int i = 0; i < 30 && rise2 < 0; i++) begin
      @(negedge clk);
      if (irq === 1'b1 && !prev) begin
        if (rise1 < 0) begin rise1 = i; v1 = vec; end
        else begin rise2 = i; v2 = vec; end
      end
      prev = irq;
      cpu_ack = irq;
    end
    cpu_ack = 1'b0;
    vectors++;
    if (rise1 < 0 || rise2 - rise1 != 4) begin
      miscompares++; $display("FAIL b2b_spacing got %0d want 4", rise2 - rise1);
    end
    vectors++;
    if (v1 !== 6'h11 || v2 !== 6'h27) begin
      miscompares++; $display("FAIL b2b_vec got %h,%h want 11,27", v1, v2);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid;
    req_b[0] = 1'b1;
    @(negedge clk);
    req_b[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_irq got %b want 1", irq);
    end
    rst = 1'b1; cpu_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_ack = 1'b0;
    vectors++;
    if (irq !== 1'b0 || {pend_c, pend_b, pend_a} !== 27'h0 || vec !== 6'h00 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_state got irq=%b pend=%h vec=%h err=%b want 0/0/00/0",
               irq, {pend_c, pend_b, pend_a}, vec, err);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({ack_c, ack_b, ack_a} !== 27'h0 || irq !== 1'b0) begin
        miscompares++; $display("FAIL rstmid_noack got ack=%h irq=%b want 0/0", {ack_c, ack_b, ack_a}, irq);
      end
    end
  endtask

  task automatic test_random;
    logic [26:0] r;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      vectors++;
      if ({pend_c, pend_b, pend_a, ack_c, ack_b, ack_a, irq, vec, err} !==
          {m_pend, m_ack, m_irq, m_vec, m_err}) begin
        miscompares++;
        $display("FAIL random_cycle%0d got %h want %h", i,
                 {pend_c, pend_b, pend_a, ack_c, ack_b, ack_a, irq, vec, err},
                 {m_pend, m_ack, m_irq, m_vec, m_err});
      end
      vectors++;
      if ($countones({ack_c, ack_b, ack_a}) > 1) begin
        miscompares++; $display("FAIL random_onehot got %h want <=1 bit", {ack_c, ack_b, ack_a});
      end
      r = {req_c, req_b, req_a};
      if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 26)] ^= 1'b1;
      {req_c, req_b, req_a} = r;
      if ($urandom_range(0, 2) == 0) cpu_ack = ~cpu_ack;
    end
    req_a = '0; req_b = '0; req_c = '0;
    @(negedge clk);
    drain("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_group_priority();
    test_invalid_code();
    test_timeout();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
